// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one ready/valid memory port between two masters: port 0 (core
//   fetch/load/store) and port 1 (debug/DMA loader). Only one transaction is
//   outstanding at a time. A granted master owns the memory until the response
//   pulse arrives, and the response is returned to that master only.
//
//   Build option: define MEMORY_ARBITER_ROUND_ROBIN_EN to make contended
//   grants alternate between the ports. If it is left undefined, port 0 always
//   wins contention.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_request,
  input  logic                    m0_enable,
  input  logic                    m0_command,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_write_mask,
  output logic                    m0_ready,
  output logic                    m0_valid,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  input  logic                    m1_request,
  input  logic                    m1_enable,
  input  logic                    m1_command,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_write_mask,
  output logic                    m1_ready,
  output logic                    m1_valid,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  input  logic                    memory_ready,
  input  logic                    memory_valid,
  input  logic [DATA_WIDTH-1:0]   memory_read_data,
  output logic                    memory_enable,
  output logic                    memory_command,
  output logic [ADDR_WIDTH-1:0]   memory_address,
  output logic [DATA_WIDTH-1:0]   memory_write_data,
  output logic [DATA_WIDTH/8-1:0] memory_write_mask,
  output logic                    debug_state,
  output logic                    debug_owner
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic       owner;
  logic       last_served;
  logic       grant;
  logic       grant_any;
  logic       ready_ok;
  logic       accept;
  logic       resp;

  // Choose a requester. Requests never depend on ready, so there is no loop.
  always_comb begin
    grant_any = m0_request | m1_request;
    grant     = 1'b0;
    if (m0_request && m1_request) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      grant = ~last_served;
`else
      grant = 1'b0;
`endif
    end else if (m1_request) begin
      grant = 1'b1;
    end
  end

  // Ready, accept and the request mux that passes through to memory unregistered.
  always_comb begin
    ready_ok          = !reset && (state == IDLE) && grant_any && memory_ready;
    m0_ready          = ready_ok && !grant;
    m1_ready          = ready_ok && grant;
    accept            = (m0_ready && m0_enable) || (m1_ready && m1_enable);
    memory_enable     = accept;
    memory_command    = grant ? m1_command    : m0_command;
    memory_address    = grant ? m1_address    : m0_address;
    memory_write_data = grant ? m1_write_data : m0_write_data;
    memory_write_mask = grant ? m1_write_mask : m0_write_mask;
  end

  // Route the response pulse to the owner only. In BUSY, last_served always
  // equals owner because both are loaded on the same accept.
  always_comb begin
    resp         = !reset && (state == BUSY) && memory_valid;
    m0_valid     = resp && !last_served;
    m1_valid     = resp && last_served;
    m0_read_data = memory_read_data;
    m1_read_data = memory_read_data;
    debug_state  = state[0];
    debug_owner  = owner;
  end

  // IDLE/BUSY sequencing. A reset abandons any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= BUSY;
            owner       <= grant;
            last_served <= grant;
          end
        end
        default: begin
          if (memory_valid) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Testbench for memory_port_arbiter.
// Directed stimulus. Expected responses are pushed into a queue when a
// transaction is accepted, and a monitor pops and compares them on every
// mN_valid. Contention expectations follow MEMORY_ARBITER_ROUND_ROBIN_EN.
module tb_memory_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_request, m0_enable, m0_command;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_write_data;
  logic [MW-1:0] m0_write_mask;
  logic          m0_ready, m0_valid;
  logic [DW-1:0] m0_read_data;
  logic          m1_request, m1_enable, m1_command;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_write_data;
  logic [MW-1:0] m1_write_mask;
  logic          m1_ready, m1_valid;
  logic [DW-1:0] m1_read_data;
  logic          memory_ready, memory_valid;
  logic [DW-1:0] memory_read_data;
  logic          memory_enable, memory_command;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data;
  logic [MW-1:0] memory_write_mask;
  logic          debug_state, debug_owner;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_request(m0_request), .m0_enable(m0_enable), .m0_command(m0_command),
    .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_write_mask(m0_write_mask),
    .m0_ready(m0_ready), .m0_valid(m0_valid), .m0_read_data(m0_read_data),
    .m1_request(m1_request), .m1_enable(m1_enable), .m1_command(m1_command),
    .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_write_mask(m1_write_mask),
    .m1_ready(m1_ready), .m1_valid(m1_valid), .m1_read_data(m1_read_data),
    .memory_ready(memory_ready), .memory_valid(memory_valid), .memory_read_data(memory_read_data),
    .memory_enable(memory_enable), .memory_command(memory_command), .memory_address(memory_address),
    .memory_write_data(memory_write_data), .memory_write_mask(memory_write_mask),
    .debug_state(debug_state), .debug_owner(debug_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a memory response for one cycle; nobody may be ready while busy.
  task automatic respond(input logic [DW-1:0] d);
    memory_valid     = 1'b1;
    memory_read_data = d;
    @(negedge clk);
    chk("resp_cycle_m0_ready", m0_ready, 1'b0);
    chk("resp_cycle_m1_ready", m1_ready, 1'b0);
    step();
    memory_valid = 1'b0;
  endtask

  // Scoreboard monitor: every response pulse must match the queue head.
  always @(negedge clk) begin
    if (m0_valid || m1_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {m1_valid, m0_valid}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_port", {m1_valid, m0_valid}, mon_e.port ? 2'b10 : 2'b01);
        chk("resp_data", mon_e.port ? m1_read_data : m0_read_data, mon_e.data);
      end
    end
  end

  logic ord [3];

  initial begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    ord = '{1'b0, 1'b1, 1'b0};
`else
    ord = '{1'b0, 1'b0, 1'b0};
`endif
    reset = 1'b1;
    m0_request = 1'b1; m0_enable = 1'b1; m0_command = 1'b0;
    m0_address = '0; m0_write_data = '0; m0_write_mask = '0;
    m1_request = 1'b0; m1_enable = 1'b0; m1_command = 1'b0;
    m1_address = '0; m1_write_data = '0; m1_write_mask = '0;
    memory_ready = 1'b1; memory_valid = 1'b0; memory_read_data = '0;

    // Reset: nothing ready or enabled even with a live request
    @(negedge clk);
    chk("reset_m0_ready", m0_ready, 1'b0);
    chk("reset_mem_enable", memory_enable, 1'b0);
    step();
    reset = 1'b0; m0_request = 1'b0; m0_enable = 1'b0;
    @(negedge clk);
    chk("reset_state", debug_state, 1'b0);
    chk("reset_owner", debug_owner, 1'b0);

    // Test 1: m0 read at 0x100, response two cycles later
    step();
    m0_request = 1'b1; m0_enable = 1'b1; m0_command = 1'b0; m0_address = 32'h100;
    @(negedge clk);
    chk("t1_m0_ready", m0_ready, 1'b1);
    chk("t1_m1_ready", m1_ready, 1'b0);
    chk("t1_mem_enable", memory_enable, 1'b1);
    chk("t1_mem_addr", memory_address, 32'h100);
    chk("t1_mem_cmd", memory_command, 1'b0);
    exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF});
    step();
    m0_request = 1'b0; m0_enable = 1'b0;
    @(negedge clk);
    chk("t1_busy_state", debug_state, 1'b1);
    chk("t1_busy_mem_enable", memory_enable, 1'b0);
    step();
    respond(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_back_idle", debug_state, 1'b0);

    // Tests 2/3: both request continuously from reset
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_request = 1'b1; m0_enable = 1'b1; m0_address = 32'h200;
    m1_request = 1'b1; m1_enable = 1'b1; m1_address = 32'h300; m1_command = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_m0_ready", m0_ready, !ord[i]);
      chk("t2_m1_ready", m1_ready, ord[i]);
      chk("t2_mem_addr", memory_address, ord[i] ? 32'h300 : 32'h200);
      exp_q.push_back('{port: ord[i], data: 32'hA000_0000 + i});
      step();
      respond(32'hA000_0000 + i);
    end
    m0_request = 1'b0; m0_enable = 1'b0;
    @(negedge clk);
    chk("t2_m1_served_ready", m1_ready, 1'b1);
    chk("t2_m1_served_m0_ready", m0_ready, 1'b0);
    exp_q.push_back('{port: 1'b1, data: 32'hB0B0B0B0});
    step();
    m1_request = 1'b0; m1_enable = 1'b0;
    @(negedge clk);
    chk("t2_owner_m1", debug_owner, 1'b1);
    step();
    respond(32'hB0B0B0B0);

    // Test 4: m1 write waits while m0 is busy
    m0_request = 1'b1; m0_enable = 1'b1; m0_command = 1'b0; m0_address = 32'h400;
    @(negedge clk);
    chk("t4_m0_accept", memory_enable, 1'b1);
    exp_q.push_back('{port: 1'b0, data: 32'h11112222});
    step();
    m0_request = 1'b0; m0_enable = 1'b0;
    m1_request = 1'b1; m1_enable = 1'b1; m1_command = 1'b1; m1_address = 32'h500;
    m1_write_data = 32'h55AA00FF; m1_write_mask = 4'b0101;
    @(negedge clk);
    chk("t4_m1_ready_busy", m1_ready, 1'b0);
    chk("t4_mem_enable_busy", memory_enable, 1'b0);
    step();
    respond(32'h11112222);
    @(negedge clk);
    chk("t4_m1_ready", m1_ready, 1'b1);
    chk("t4_mem_enable", memory_enable, 1'b1);
    chk("t4_mem_cmd", memory_command, 1'b1);
    chk("t4_mem_addr", memory_address, 32'h500);
    chk("t4_mem_wdata", memory_write_data, 32'h55AA00FF);
    chk("t4_mem_mask", memory_write_mask, 4'b0101);
    exp_q.push_back('{port: 1'b1, data: 32'h0BADF00D});
    step();
    m1_request = 1'b0; m1_enable = 1'b0; m1_command = 1'b0;
    respond(32'h0BADF00D);

    // Test 5: enable without ready is ignored; stray response is dropped
    m1_enable = 1'b1;
    @(negedge clk);
    chk("t5_noreq_ready", m1_ready, 1'b0);
    chk("t5_noreq_mem_enable", memory_enable, 1'b0);
    m1_request = 1'b1; memory_ready = 1'b0;
    @(negedge clk);
    chk("t5_memnotready_ready", m1_ready, 1'b0);
    chk("t5_memnotready_mem_enable", memory_enable, 1'b0);
    step();
    memory_ready = 1'b1; m1_request = 1'b0; m1_enable = 1'b0; memory_valid = 1'b1;
    @(negedge clk);
    chk("t5_still_idle", debug_state, 1'b0);
    chk("t5_stray_m0_valid", m0_valid, 1'b0);
    chk("t5_stray_m1_valid", m1_valid, 1'b0);
    step();
    memory_valid = 1'b0;

    // Test 6: reset while busy discards the response
    m1_request = 1'b1; m1_enable = 1'b1; m1_address = 32'h700;
    @(negedge clk);
    chk("t6_m1_ready", m1_ready, 1'b1);
    step();
    m1_request = 1'b0; m1_enable = 1'b0;
    @(negedge clk);
    chk("t6_busy_state", debug_state, 1'b1);
    chk("t6_busy_owner", debug_owner, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0; memory_valid = 1'b1; memory_read_data = 32'hBADBAD00;
    @(negedge clk);
    chk("t6_reset_state", debug_state, 1'b0);
    chk("t6_reset_owner", debug_owner, 1'b0);
    chk("t6_late_m0_valid", m0_valid, 1'b0);
    chk("t6_late_m1_valid", m1_valid, 1'b0);
    step();
    memory_valid = 1'b0;
    m0_request = 1'b1; m0_enable = 1'b1; m0_address = 32'h600;
    @(negedge clk);
    chk("t6_m0_ready", m0_ready, 1'b1);
    chk("t6_m0_mem_enable", memory_enable, 1'b1);
    exp_q.push_back('{port: 1'b0, data: 32'h600DD00D});
    step();
    m0_request = 1'b0; m0_enable = 1'b0;
    respond(32'h600DD00D);
    @(negedge clk);
    chk("t6_final_idle", debug_state, 1'b0);

    chk("all_responses_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
